// File: rtl/fifo_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_reader_pkg
// Purpose : Shared FSM state encoding and buffer sizing for fifo_reader.
// Revision: 1.0 - initial release
// ============================================================================
package fifo_reader_pkg;

    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_reader_if.sv
`default_nettype none
// ============================================================================
// Module  : fifo_reader_if
// Purpose : FIFO read port plus valid/ready output stream of fifo_reader.
// Revision: 1.0 - initial release
// ============================================================================
interface fifo_reader_if #(
    parameter int FIFO_WIDTH = 16
);
    logic                  fifo_rd_en;
    logic [FIFO_WIDTH-1:0] fifo_data_out;
    logic                  fifo_empty;
    logic                  fifo_underflow;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output fifo_rd_en,
        input  fifo_data_out,
        input  fifo_empty,
        input  fifo_underflow,
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_data_out,
        output fifo_empty,
        output fifo_underflow,
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface
`default_nettype wire

// File: rtl/fifo_reader_skid.sv
`default_nettype none
// ============================================================================
// Module  : fifo_reader_skid
// Purpose : Two-entry in-order buffer absorbing the FIFO read latency.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] r_mem [BUF_DEPTH];
    logic             r_head_ptr;
    logic [1:0]       r_occ;
    logic             w_tail_ptr;

    // A push never arrives while full, so the tail is head + occ (mod 2).
    assign w_tail_ptr = r_head_ptr ^ r_occ[0];

    generate
        for (genvar g = 0; g < BUF_DEPTH; g++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[g] <= '0;
                end else if (push && (w_tail_ptr == 1'(g))) begin
                    r_mem[g] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_ptr <= 1'b0;
            r_occ      <= 2'd0;
        end else begin
            if (pop) begin
                r_head_ptr <= ~r_head_ptr;
            end
            r_occ <= r_occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign occ  = r_occ;
    assign head = r_mem[r_head_ptr];

endmodule
`default_nettype wire

// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
// Module  : fifo_reader
// Purpose : FIFO read-side controller re-presenting words as valid/ready.
//           Optional burst mode (burst_len/start/done) under READER_BURST_EN.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    fifo_reader_if.master                bus,
    input  logic                         enable,
    input  logic                         err_clr,
`ifdef READER_BURST_EN
    input  logic [$clog2(FIFO_DEPTH):0]  burst_len,
    input  logic                         start,
    output logic                         done,
`endif
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         rd_count,
    output logic                         err_underflow
);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_inflight;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_err;
    logic [1:0]            w_occ;
    logic [FIFO_WIDTH-1:0] w_head;
    logic                  w_pop;
    logic                  w_rd_en;
    logic [2:0]            w_level;
    logic                  w_issue_ok;

    fifo_reader_skid #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_inflight),
        .push_data (bus.fifo_data_out),
        .pop       (w_pop),
        .occ       (w_occ),
        .head      (w_head)
    );

    assign bus.m_valid = (w_occ != 2'd0);
    assign bus.m_data  = w_head;
    assign w_pop       = bus.m_valid && bus.m_ready;

    // Slots already committed after this cycle's pop: buffered plus in flight.
    assign w_level = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};

`ifdef READER_BURST_EN
    localparam int BL_W = $clog2(FIFO_DEPTH) + 1;

    logic [BL_W-1:0] r_remaining;
    logic            r_burst;
    logic            r_done;
    logic            w_load;
    logic            w_last;

    assign w_last     = r_burst && w_pop && (r_remaining == BL_W'(1));
    assign w_issue_ok = !r_burst ||
                        (({{(BL_W-2){1'b0}}, w_occ} + {{(BL_W-1){1'b0}}, r_inflight}) < r_remaining);
    assign done       = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= '0;
            r_burst     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_remaining <= burst_len;
                r_burst     <= 1'b1;
            end else begin
                if (r_burst && w_pop) begin
                    r_remaining <= r_remaining - BL_W'(1);
                end
                if (w_last) begin
                    r_burst <= 1'b0;
                end
            end
        end
    end
`else
    assign w_issue_ok = 1'b1;
`endif

    always_comb begin
        w_state_next = r_state;
`ifdef READER_BURST_EN
        w_load       = 1'b0;
`endif
        case (r_state)
            IDLE: begin
`ifdef READER_BURST_EN
                if (start && (burst_len != '0)) begin
                    w_state_next = RUN;
                    w_load       = 1'b1;
                end else if (enable) begin
                    w_state_next = RUN;
                end
`else
                if (enable) begin
                    w_state_next = RUN;
                end
`endif
            end
            RUN: begin
`ifdef READER_BURST_EN
                if (r_burst) begin
                    if (w_last) begin
                        w_state_next = IDLE;
                    end
                end else if (!enable) begin
                    w_state_next = DRAIN;
                end
`else
                if (!enable) begin
                    w_state_next = DRAIN;
                end
`endif
            end
            DRAIN: begin
                if (enable) begin
                    w_state_next = RUN;
                end else if ((w_occ == 2'd0) && !r_inflight) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_rd_en = (r_state == RUN) && !bus.fifo_empty && (w_level < 3'd2) && w_issue_ok;
    assign bus.fifo_rd_en = w_rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_rd_en;
            if (w_pop) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
            // Underflow wins over a coincident clear.
            r_err <= bus.fifo_underflow | (r_err & ~err_clr);
        end
    end

    assign busy          = (r_state != IDLE);
    assign rd_count      = r_count;
    assign err_underflow = r_err;

endmodule
`default_nettype wire
